spi_cfg_master: RTL and testbench

//   On-chip SPI controller that configures the SPI register-bank peripheral (en_reg_out/en_reg_pwm/duty).

---
 rtl/spi_cfg_master.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// SPI write-only configuration master: FIFO of (addr,data) commands,
// each sent as a 16-bit mode-0 frame {1,addr,data}, MSB first.
// Ports: clk, rst_n, cmd_valid/cmd_ready/cmd_addr/cmd_data (command in),
// fifo_level, busy, done, err_drop (status), sclk/ncs/copi (SPI out).
// Option: SPI_CFG_ADDR_CHECK_EN drops commands with addr > 7'h04.
module spi_cfg_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [6:0]                        cmd_addr,
  input  logic [7:0]                        cmd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy,
  output logic                              done,
  output logic                              err_drop,
  output logic                              sclk,
  output logic                              ncs,
  output logic                              copi
);

  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HC_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   hc_q, hc_d;
  logic [3:0]      bit_q, bit_d;
  logic [14:0]     sh_q, sh_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            copi_q, copi_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [14:0]     mem [FIFO_DEPTH];
  logic [14:0]     head;
  logic            push;
  logic            pop;
  logic            addr_bad;

  assign head = mem[rd_ptr_q];
  assign push = cmd_valid & rdy_q;

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign addr_bad = (head[14:8] > 7'h04);
`else
  assign addr_bad = 1'b0;
`endif

  // Frame sequencer. sh holds the 15 bits after the leading write bit;
  // its MSB is always the next bit to drive on copi.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        hc_d = '0;
        if (level_q != '0) begin
          pop = 1'b1;
          if (addr_bad) begin
            drop_d = 1'b1;
          end else begin
            sh_d    = head;
            ncs_d   = 1'b0;
            copi_d  = 1'b1;
            bit_d   = '0;
            state_d = S_LEAD;
          end
        end
      end
      S_LEAD: begin
        hc_d = hc_q + CW'(1);
        if (hc_q == HC_END) begin
          hc_d    = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        hc_d = hc_q + CW'(1);
        if (hc_q == HC_END) begin
          hc_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = S_TRAIL;
          end else begin
            copi_d  = sh_q[14];
            sh_d    = {sh_q[13:0], 1'b0};
            bit_d   = bit_q + 4'd1;
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        hc_d = hc_q + CW'(1);
        if (hc_q == HC_END) begin
          hc_d    = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_TRAIL: begin
        hc_d = hc_q + CW'(1);
        if (hc_q == HC_END) begin
          hc_d    = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        hc_d = hc_q + CW'(1);
        if (hc_q == GAP_END) begin
          hc_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
        sclk_d  = 1'b0;
        ncs_d   = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping. Ready is precomputed from next-state values so that
  // a full FIFO still accepts on the very cycle an entry is popped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
    rdy_d   = (level_d != LVL_FULL) ||
              ((state_d == S_IDLE) && (level_d != '0));
    busy_d  = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hc_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      copi_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      ncs_q    <= ncs_d;
      copi_q   <= copi_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read below the level count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  assign cmd_ready  = rdy_q;
  assign fifo_level = level_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_drop   = drop_q;
  assign sclk       = sclk_q;
  assign ncs        = ncs_q;
  assign copi       = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with an SPI mode-0 receiver model
// standing in for the register-bank peripheral (regs 0..4).
module tb_spi_cfg_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [2:0] fifo_level;
  logic       busy, done, err_drop, sclk, ncs, copi;

  int n_cmp = 0;
  int n_bad = 0;

  spi_cfg_master #(
    .CLK_DIV(4), .FIFO_DEPTH(4), .CS_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .fifo_level(fifo_level), .busy(busy),
    .done(done), .err_drop(err_drop),
    .sclk(sclk), .ncs(ncs), .copi(copi)
  );

  always #5 clk = ~clk;

  // Receiver model, sampled on the falling clk edge.
  int cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int last_low = 0, last_gap = 0, gap_min = 1000;
  int cur_rises = 0, last_rises = 0, rx_cnt = 0;
  int setup_viol = 0, hold_viol = 0, copi_chg = 0;
  int done_cnt = 0, drop_cnt = 0, fall_cnt = 0;
  bit have_rise = 1'b0;
  logic ncs_p = 1'b1, sclk_p = 1'b0, copi_p = 1'b0;
  logic [15:0] rx_sh = '0;
  logic [15:0] frames[$];
  logic [7:0]  regs[5] = '{default: 8'h00};

  always @(negedge clk) begin
    cyc++;
    if (ncs_p && !ncs) begin
      rx_cnt = 0; cur_rises = 0; fall_cyc = cyc; fall_cnt++;
      if (have_rise) begin
        last_gap = cyc - rise_cyc;
        if (last_gap < gap_min) gap_min = last_gap;
      end
    end
    if (!ncs && sclk && !sclk_p) begin
      rx_sh = {rx_sh[14:0], copi};
      rx_cnt++; cur_rises++;
      if (cyc - copi_chg < 4) setup_viol++;
    end
    if (sclk && sclk_p && copi !== copi_p) hold_viol++;
    if (copi !== copi_p) copi_chg = cyc;
    if (!ncs_p && ncs) begin
      rise_cyc = cyc; have_rise = 1'b1;
      last_low = cyc - fall_cyc; last_rises = cur_rises;
      if (rx_cnt == 16) begin
        frames.push_back(rx_sh);
        if (rx_sh[15] && rx_sh[14:8] <= 7'h04)
          regs[rx_sh[10:8]] = rx_sh[7:0];
      end
    end
    if (done) done_cnt++;
    if (err_drop) drop_cnt++;
    ncs_p = ncs; sclk_p = sclk; copi_p = copi;
  end

  task automatic clear_mon();
    frames.delete();
    done_cnt = 0; drop_cnt = 0; fall_cnt = 0;
    gap_min = 1000; setup_viol = 0; hold_viol = 0;
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic push(input logic [6:0] a, input logic [7:0] d);
    int t = 0;
    cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL push_accept addr=%h got ready=%b want 1", a, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while ((busy || !ncs) && t < bound) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if (busy || !ncs) begin
      n_bad++;
      $display("FAIL idle_timeout got busy=%b ncs=%b want 0/1", busy, ncs);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ncs, sclk, copi, done, err_drop} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_pins got %b want 10000",
               {ncs, sclk, copi, done, err_drop});
    end
    n_cmp++;
    if (fifo_level !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_level got %0d want 0", fifo_level);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, cmd_ready, ncs} !== 3'b011) begin
      n_bad++;
      $display("FAIL reset_idle got %b want 011", {busy, cmd_ready, ncs});
    end
  endtask

  task automatic test_single();
    clear_mon();
    push(7'h00, 8'hA5);
    wait_idle(400);
    n_cmp++;
    if (frames.size() != 1 || frames[0] !== 16'h80A5) begin
      n_bad++;
      $display("FAIL single_frame got n=%0d f=%h want 1 80a5",
               frames.size(), frames.size() ? frames[0] : 16'h0);
    end
    n_cmp++;
    if (last_low != 132) begin
      n_bad++;
      $display("FAIL single_ncs_low got %0d want 132", last_low);
    end
    n_cmp++;
    if (last_rises != 16) begin
      n_bad++;
      $display("FAIL single_rises got %0d want 16", last_rises);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL single_done got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (regs[0] !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_reg0 got %h want a5", regs[0]);
    end
    n_cmp++;
    if (setup_viol != 0 || hold_viol != 0) begin
      n_bad++;
      $display("FAIL single_copi_timing got %0d/%0d want 0/0",
               setup_viol, hold_viol);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      push(7'(i), d);
    end
    wait_idle(1200);
    n_cmp++;
    if (frames.size() != 5) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 5", frames.size());
    end
    for (int i = 0; i < 5 && i < frames.size(); i++) begin
      d = 8'(8'h11 * (i + 1));
      n_cmp++;
      if (frames[i] !== {1'b1, 7'(i), d}) begin
        n_bad++;
        $display("FAIL b2b_frame%0d got %h want %h",
                 i, frames[i], {1'b1, 7'(i), d});
      end
      n_cmp++;
      if (regs[i] !== d) begin
        n_bad++;
        $display("FAIL b2b_reg%0d got %h want %h", i, regs[i], d);
      end
    end
    n_cmp++;
    if (gap_min != 5) begin
      n_bad++;
      $display("FAIL b2b_gap got %0d want 5", gap_min);
    end
    n_cmp++;
    if (done_cnt != 5 || setup_viol != 0 || hold_viol != 0) begin
      n_bad++;
      $display("FAIL b2b_done_timing got %0d/%0d/%0d want 5/0/0",
               done_cnt, setup_viol, hold_viol);
    end
  endtask

  task automatic test_fifo_full();
    logic [15:0] exp[6];
    int t = 0;
    exp = '{16'h8001, 16'h8121, 16'h8222, 16'h8323,
            16'h8424, 16'h8025};
    clear_mon();
    push(7'h00, 8'h01);
    while (ncs && t < 50) begin
      @(negedge clk); t++;
    end
    for (int i = 1; i < 5; i++) push(7'(i), 8'(8'h20 + i));
    n_cmp++;
    if ({fifo_level, cmd_ready, busy, ncs} !== {3'd4, 3'b010}) begin
      n_bad++;
      $display("FAIL full_state got lvl=%0d rdy=%b busy=%b ncs=%b want 4 0 1 0",
               fifo_level, cmd_ready, busy, ncs);
    end
    cmd_addr = 7'h00; cmd_data = 8'h25; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 400) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if ({cmd_ready, ncs, fifo_level} !== {2'b11, 3'd4}) begin
      n_bad++;
      $display("FAIL full_held_ready got rdy=%b ncs=%b lvl=%0d want 1 1 4",
               cmd_ready, ncs, fifo_level);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({ncs, fifo_level} !== {1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL full_push_pop got ncs=%b lvl=%0d want 0 4",
               ncs, fifo_level);
    end
    wait_idle(1200);
    n_cmp++;
    if (frames.size() != 6) begin
      n_bad++;
      $display("FAIL full_count got %0d want 6", frames.size());
    end
    for (int i = 0; i < 6 && i < frames.size(); i++) begin
      n_cmp++;
      if (frames[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL full_order%0d got %h want %h", i, frames[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] snap;
    int nf;
    int nfall;
    int t = 0;
    snap = regs[4];
    clear_mon();
    push(7'h04, 8'h80);
    while (ncs && t < 50) begin
      @(negedge clk); t++;
    end
    push(7'h01, 8'h77);
    n_cmp++;
    if (fifo_level !== 3'd1) begin
      n_bad++;
      $display("FAIL mid_level_pre got %0d want 1", fifo_level);
    end
    t = 0;
    while (cur_rises < 8 && t < 200) begin
      @(posedge clk); t++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ncs, sclk} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_abort got ncs=%b sclk=%b want 1 0", ncs, sclk);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nf = frames.size();
    nfall = fall_cnt;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_flush got lvl=%0d busy=%b want 0 0", fifo_level, busy);
    end
    n_cmp++;
    if (frames.size() != nf || fall_cnt != nfall || nf != 0) begin
      n_bad++;
      $display("FAIL mid_no_frame got frames=%0d falls=%0d want 0 %0d",
               frames.size(), fall_cnt, nfall);
    end
    n_cmp++;
    if (regs[4] !== snap) begin
      n_bad++;
      $display("FAIL mid_reg4 got %h want %h", regs[4], snap);
    end
  endtask

  task automatic test_bad_addr();
    logic [7:0] snap[5];
    snap = regs;
    clear_mon();
    push(7'h05, 8'hFF);
    wait_idle(400);
`ifdef SPI_CFG_ADDR_CHECK_EN
    n_cmp++;
    if (fall_cnt != 0 || drop_cnt != 1) begin
      n_bad++;
      $display("FAIL bad_drop got falls=%0d drops=%0d want 0 1",
               fall_cnt, drop_cnt);
    end
`else
    n_cmp++;
    if (frames.size() != 1 || drop_cnt != 0) begin
      n_bad++;
      $display("FAIL bad_frame got frames=%0d drops=%0d want 1 0",
               frames.size(), drop_cnt);
    end
    n_cmp++;
    if (frames.size() == 1 && frames[0] !== 16'h85FF) begin
      n_bad++;
      $display("FAIL bad_bits got %h want 85ff", frames[0]);
    end
`endif
    n_cmp++;
    if (fifo_level !== 3'd0) begin
      n_bad++;
      $display("FAIL bad_level got %0d want 0", fifo_level);
    end
    n_cmp++;
    if (regs != snap) begin
      n_bad++;
      $display("FAIL bad_regs got %h want %h", regs[0], snap[0]);
    end
  endtask

  task automatic test_done_push();
    int t = 0;
    clear_mon();
    push(7'h02, 8'h5A);
    while (!done && t < 400) begin
      @(negedge clk); t++;
    end
    cmd_addr = 7'h03; cmd_data = 8'h3C; cmd_valid = 1'b1;
    n_cmp++;
    if ({done, cmd_ready, fifo_level} !== {2'b11, 3'd0}) begin
      n_bad++;
      $display("FAIL donepush_ready got done=%b rdy=%b lvl=%0d want 1 1 0",
               done, cmd_ready, fifo_level);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd1) begin
      n_bad++;
      $display("FAIL donepush_level got %0d want 1", fifo_level);
    end
    wait_idle(400);
    n_cmp++;
    if (frames.size() != 2 || frames[1] !== 16'h833C) begin
      n_bad++;
      $display("FAIL donepush_frame got n=%0d want 2 with 833c", frames.size());
    end
    n_cmp++;
    if (last_gap < 5 || last_gap > 6) begin
      n_bad++;
      $display("FAIL donepush_gap got %0d want 5..6", last_gap);
    end
    n_cmp++;
    if (regs[3] !== 8'h3C || regs[2] !== 8'h5A) begin
      n_bad++;
      $display("FAIL donepush_regs got %h %h want 5a 3c", regs[2], regs[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_bad_addr();
    test_done_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
